// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the fetch PC unit: the fetch
//               FSM state encoding, the prediction record that travels with
//               each instruction, and the default reset fetch address.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Widest address the prediction record can carry.
  localparam int FETCH_TARGET_W = 64;

  // Default first fetch address after reset.
  localparam logic [FETCH_TARGET_W-1:0] FETCH_RESET_PC = 64'h0;

  typedef enum logic [1:0] {
    REQ  = 2'd0,  // request outstanding at pc_q
    HOLD = 2'd1,  // instruction parked while decode is stalled
    KILL = 2'd2   // waiting out a request that a redirect made stale
  } fetch_state_t;

  typedef struct packed {
    logic                      pred_taken;
    logic [1:0]                btb_way;
    logic [FETCH_TARGET_W-1:0] target;
  } fetch_pred_t;

endpackage
`default_nettype wire

// File: rtl/fetch_next_pc.sv
`default_nettype none
// ============================================================================
// Module      : fetch_next_pc
// Description : Combinational next-PC select. Produces PC+4 (wrapping) and
//               the next fetch address: the predicted target when taken,
//               otherwise PC+4, always word aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_next_pc #(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  pred_taken,
  input  logic [ADDR_WIDTH-1:0] target,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic [ADDR_WIDTH-1:0] next_pc
);

  // Sequential vs predicted select; the low two bits are cleared so every
  // address that reaches the PC register is instruction aligned.
  always_comb begin
    pc_plus4     = pc + ADDR_WIDTH'(4);
    next_pc      = pred_taken ? target : pc_plus4;
    next_pc[1:0] = 2'b00;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Fetch-stage PC and I-cache request unit. Owns the fetch PC,
//               handshakes with the instruction cache, and hands one
//               instruction per cycle (with PC and BTB metadata) to decode.
//               Stalls park the instruction in a hold buffer; redirects that
//               land on an outstanding miss wait out the stale response.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(FETCH_RESET_PC)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_stall_fetch,
  input  logic                   i_redirect,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_addr,
  input  logic                   i_branch_pred_taken,
  input  logic [1:0]             i_btb_way,
  input  logic [ADDR_WIDTH-1:0]  i_pc_target_addr_pred,
  output logic                   o_icache_req,
  output logic [ADDR_WIDTH-1:0]  o_icache_addr,
  input  logic                   i_icache_ack,
  input  logic [INSTR_WIDTH-1:0] i_icache_instr,
  output logic                   o_fetch_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
  output logic                   o_branch_pred_taken,
  output logic [1:0]             o_btb_way,
  output logic [ADDR_WIDTH-1:0]  o_pc_target_addr_pred
);

  fetch_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
  logic [INSTR_WIDTH-1:0] hold_instr_q;
  fetch_pred_t            hold_pred_q;
  fetch_pred_t            live_pred;
  fetch_pred_t            sel_pred;
  logic                   hold_load;
  logic [ADDR_WIDTH-1:0]  next_pc;
  logic [ADDR_WIDTH-1:0]  pc_plus4;
  logic [ADDR_WIDTH-1:0]  redirect_pc;

  assign redirect_pc = {i_redirect_addr[ADDR_WIDTH-1:2], 2'b00};

  // Prediction for the instruction at o_pc: live BTB lookup normally, the
  // copy captured alongside the parked instruction while in HOLD.
  always_comb begin
    live_pred.pred_taken = i_branch_pred_taken;
    live_pred.btb_way    = i_btb_way;
    live_pred.target     = FETCH_TARGET_W'(i_pc_target_addr_pred);
    sel_pred             = (state_q == HOLD) ? hold_pred_q : live_pred;
  end

  fetch_next_pc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_pc (
    .pc         (pc_q),
    .pred_taken (sel_pred.pred_taken),
    .target     (ADDR_WIDTH'(sel_pred.target)),
    .pc_plus4   (pc_plus4),
    .next_pc    (next_pc)
  );

  assign o_pc       = pc_q;
  assign o_pc_plus4 = pc_plus4;

  // Next-state, PC update and cache-request decode; redirect outranks ack/stall.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    hold_load     = 1'b0;
    o_icache_req  = 1'b0;
    o_icache_addr = pc_q;
    o_fetch_valid = 1'b0;
    unique case (state_q)
      REQ: begin
        o_icache_req = 1'b1;
        if (i_redirect) begin
          pc_d = redirect_pc;
          if (!i_icache_ack) begin
            // Response still in flight: remember its address so the request
            // stays stable until the cache answers, then drop the data.
            req_addr_d = pc_q;
            state_d    = KILL;
          end
        end else if (i_icache_ack) begin
          o_fetch_valid = 1'b1;
          if (i_stall_fetch) begin
            hold_load = 1'b1;
            state_d   = HOLD;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      HOLD: begin
        if (i_redirect) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end else begin
          o_fetch_valid = 1'b1;
          if (!i_stall_fetch) begin
            pc_d    = next_pc;
            state_d = REQ;
          end
        end
      end
      KILL: begin
        o_icache_req  = 1'b1;
        o_icache_addr = req_addr_q;
        if (i_redirect) begin
          pc_d = redirect_pc;
        end
        if (i_icache_ack) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  // Data presented to decode; zero whenever nothing valid is offered.
  always_comb begin
    o_instr               = '0;
    o_branch_pred_taken   = 1'b0;
    o_btb_way             = 2'b00;
    o_pc_target_addr_pred = '0;
    if (o_fetch_valid) begin
      o_instr               = (state_q == HOLD) ? hold_instr_q : i_icache_instr;
      o_branch_pred_taken   = sel_pred.pred_taken;
      o_btb_way             = sel_pred.btb_way;
      o_pc_target_addr_pred = ADDR_WIDTH'(sel_pred.target);
    end
  end

  // State, PC, stale-request address and hold buffer registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= REQ;
      pc_q         <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
      req_addr_q   <= RESET_PC;
      hold_instr_q <= '0;
      hold_pred_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      if (hold_load) begin
        hold_instr_q <= i_icache_instr;
        hold_pred_q  <= live_pred;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Self-checking bench for fetch_pc_unit: directed vector table,
//               hand-written redirect/reset sequences, and a randomized run
//               against an instruction-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

  localparam int AW = 64;
  localparam int IW = 32;
  localparam logic [AW-1:0] RPC = 64'h1000;
  localparam int NV = 23;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0, stall_fetch = 1'b0, redirect = 1'b0;
  logic [AW-1:0] redirect_addr = '0, target_in = '0;
  logic          pred_taken_in = 1'b0, icache_ack = 1'b0;
  logic [1:0]    btb_way_in = 2'b00;
  logic [IW-1:0] icache_instr = '0;
  logic          icache_req, fetch_valid, pred_taken_out;
  logic [AW-1:0] icache_addr, pc, pc_plus4, target_out;
  logic [IW-1:0] instr;
  logic [1:0]    btb_way_out;

  fetch_pc_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(RPC)) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_stall_fetch         (stall_fetch),
    .i_redirect            (redirect),
    .i_redirect_addr       (redirect_addr),
    .i_branch_pred_taken   (pred_taken_in),
    .i_btb_way             (btb_way_in),
    .i_pc_target_addr_pred (target_in),
    .o_icache_req          (icache_req),
    .o_icache_addr         (icache_addr),
    .i_icache_ack          (icache_ack),
    .i_icache_instr        (icache_instr),
    .o_fetch_valid         (fetch_valid),
    .o_instr               (instr),
    .o_pc                  (pc),
    .o_pc_plus4            (pc_plus4),
    .o_branch_pred_taken   (pred_taken_out),
    .o_btb_way             (btb_way_out),
    .o_pc_target_addr_pred (target_out)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic          rst_n, stall, redir;
    logic [AW-1:0] raddr;
    logic          pt;
    logic [1:0]    way;
    logic [AW-1:0] tgt;
    logic          ack;
    logic [IW-1:0] idata;
    logic          chk_data;
    logic          e_req;
    logic [AW-1:0] e_addr;
    logic          e_valid;
    logic [AW-1:0] e_pc;
    logic [IW-1:0] e_instr;
    logic          e_pt;
    logic [1:0]    e_way;
    logic [AW-1:0] e_tgt;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t v(
    input logic r, s, rd, input logic [AW-1:0] ra, input logic pt, input logic [1:0] w,
    input logic [AW-1:0] t, input logic a, input logic [IW-1:0] d, input logic cd,
    input logic er, input logic [AW-1:0] ea, input logic ev, input logic [AW-1:0] ep,
    input logic [IW-1:0] ei, input logic ept, input logic [1:0] ew, input logic [AW-1:0] et);
    vec_t x;
    x.rst_n = r; x.stall = s; x.redir = rd; x.raddr = ra; x.pt = pt; x.way = w; x.tgt = t;
    x.ack = a; x.idata = d; x.chk_data = cd; x.e_req = er; x.e_addr = ea; x.e_valid = ev;
    x.e_pc = ep; x.e_instr = ei; x.e_pt = ept; x.e_way = ew; x.e_tgt = et;
    return x;
  endfunction

  // One clock: inputs change 1 time unit after the rising edge, outputs are
  // sampled 1 time unit later, well before the next edge.
  task automatic drive(input logic r, s, rd, input logic [AW-1:0] ra, input logic pt,
                       input logic [1:0] w, input logic [AW-1:0] t, input logic a,
                       input logic [IW-1:0] d);
    @(posedge clk); #1;
    rst_n = r; stall_fetch = s; redirect = rd; redirect_addr = ra;
    pred_taken_in = pt; btb_way_in = w; target_in = t; icache_ack = a; icache_instr = d;
    #1;
  endtask

  task automatic cyc(input logic r, s, rd, input logic [AW-1:0] ra, input logic a, input logic [IW-1:0] d);
    drive(r, s, rd, ra, 1'b0, 2'b00, '0, a, d);
  endtask

  // ---------------- reference model helpers ----------------
  function automatic logic [IW-1:0] ihash(input logic [AW-1:0] a);
    return a[IW-1:0] ^ a[AW-1:AW-IW] ^ 32'h5A3C_96E1;
  endfunction
  function automatic logic btb_hit(input logic [AW-1:0] a);
    return (a[5:2] == 4'hB) || (a[5:2] == 4'h3);
  endfunction
  function automatic logic [AW-1:0] btb_tgt(input logic [AW-1:0] a);
    return (a + 64'h1F0) ^ 64'h1;
  endfunction
  function automatic logic [1:0] btb_w(input logic [AW-1:0] a);
    return a[7:6];
  endfunction

  logic [AW-1:0] exp_pc, cur_addr;
  logic          busy;
  int            lat, consumed;

  initial begin
    // rst s rd raddr pt w tgt ack data | cd req addr valid pc instr pt w tgt
    vt[0]  = v(0,0,0,0,      0,0,0,       0,0,           0, 0,0,      0,0,      0,           0,0,0);
    vt[1]  = v(1,0,0,0,      0,0,0,       0,0,           1, 1,'h1000, 0,'h1000, 0,           0,0,0);
    vt[2]  = v(1,0,0,0,      0,0,0,       1,'hC0DE0002,  1, 1,'h1000, 1,'h1000, 'hC0DE0002,  0,0,0);
    vt[3]  = v(1,0,0,0,      0,0,0,       1,'hC0DE0003,  1, 1,'h1004, 1,'h1004, 'hC0DE0003,  0,0,0);
    vt[4]  = v(1,0,0,0,      0,0,0,       1,'hC0DE0004,  1, 1,'h1008, 1,'h1008, 'hC0DE0004,  0,0,0);
    vt[5]  = v(1,0,0,0,      1,2,'h2000,  1,'hC0DE0005,  1, 1,'h100C, 1,'h100C, 'hC0DE0005,  1,2,'h2000);
    vt[6]  = v(1,0,0,0,      0,0,0,       0,0,           0, 1,'h2000, 0,'h2000, 0,           0,0,0);
    vt[7]  = v(1,0,0,0,      0,0,0,       0,0,           0, 1,'h2000, 0,'h2000, 0,           0,0,0);
    vt[8]  = v(1,0,0,0,      0,0,0,       1,'hC0DE0008,  1, 1,'h2000, 1,'h2000, 'hC0DE0008,  0,0,0);
    vt[9]  = v(1,1,0,0,      0,0,0,       1,'hC0DE0009,  1, 1,'h2004, 1,'h2004, 'hC0DE0009,  0,0,0);
    vt[10] = v(1,1,0,0,      0,0,0,       0,0,           1, 0,0,      1,'h2004, 'hC0DE0009,  0,0,0);
    vt[11] = v(1,0,0,0,      0,0,0,       0,0,           1, 0,0,      1,'h2004, 'hC0DE0009,  0,0,0);
    vt[12] = v(1,0,0,0,      0,0,0,       0,0,           0, 1,'h2008, 0,'h2008, 0,           0,0,0);
    vt[13] = v(1,0,1,'h3002, 0,0,0,       0,0,           0, 1,'h2008, 0,'h2008, 0,           0,0,0);
    vt[14] = v(1,0,0,0,      0,0,0,       0,0,           0, 1,'h2008, 0,'h3000, 0,           0,0,0);
    vt[15] = v(1,0,0,0,      0,0,0,       1,'hDEADBEEF,  0, 1,'h2008, 0,'h3000, 0,           0,0,0);
    vt[16] = v(1,0,0,0,      1,1,'h2001,  1,'hC0DE0010,  1, 1,'h3000, 1,'h3000, 'hC0DE0010,  1,1,'h2001);
    vt[17] = v(1,0,0,0,      0,0,0,       1,'hC0DE0011,  1, 1,'h2000, 1,'h2000, 'hC0DE0011,  0,0,0);
    vt[18] = v(1,0,1,64'hFFFF_FFFF_FFFF_FFFC, 0,0,0, 1,'hBAD0BAD0, 0, 1,'h2004, 0,'h2004, 0, 0,0,0);
    vt[19] = v(1,0,0,0,      0,0,0,       1,'hC0DE0013,  1, 1,64'hFFFF_FFFF_FFFF_FFFC, 1,
               64'hFFFF_FFFF_FFFF_FFFC, 'hC0DE0013, 0,0,0);
    vt[20] = v(1,1,0,0,      0,0,0,       1,'hC0DE0014,  1, 1,0,      1,0,      'hC0DE0014,  0,0,0);
    vt[21] = v(1,1,1,'h5000, 0,0,0,       0,0,           0, 0,0,      0,0,      0,           0,0,0);
    vt[22] = v(1,0,0,0,      0,0,0,       0,0,           0, 1,'h5000, 0,'h5000, 0,           0,0,0);

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rst_n, vt[i].stall, vt[i].redir, vt[i].raddr, vt[i].pt, vt[i].way,
            vt[i].tgt, vt[i].ack, vt[i].idata);
      if (vt[i].rst_n) begin
        check($sformatf("v%0d.req", i),   icache_req,  vt[i].e_req);
        if (vt[i].e_req) check($sformatf("v%0d.addr", i), icache_addr, vt[i].e_addr);
        check($sformatf("v%0d.valid", i), fetch_valid, vt[i].e_valid);
        check($sformatf("v%0d.pc", i),    pc,          vt[i].e_pc);
        check($sformatf("v%0d.pc4", i),   pc_plus4,    vt[i].e_pc + 64'd4);
        if (vt[i].chk_data) begin
          check($sformatf("v%0d.instr", i), instr,          vt[i].e_instr);
          check($sformatf("v%0d.pt", i),    pred_taken_out, vt[i].e_pt);
          check($sformatf("v%0d.way", i),   btb_way_out,    vt[i].e_way);
          check($sformatf("v%0d.tgt", i),   target_out,     vt[i].e_tgt);
        end
      end
    end

    // Back-to-back redirects while a stale miss is still outstanding.
    cyc(1, 0, 1, 'h6000, 0, 0);
    check("kill.addr_a", icache_addr, 'h5000);
    check("kill.valid_a", fetch_valid, 0);
    cyc(1, 0, 1, 'h7000, 0, 0);
    check("kill.addr_b", icache_addr, 'h5000);
    check("kill.pc_b", pc, 'h6000);
    cyc(1, 0, 0, 0, 1, 'h1234_5678);
    check("kill.valid_c", fetch_valid, 0);
    check("kill.pc_c", pc, 'h7000);
    cyc(1, 0, 0, 0, 0, 0);
    check("kill.req_d", icache_req, 1);
    check("kill.addr_d", icache_addr, 'h7000);

    // Reset in the middle of a miss abandons it.
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("rst.req", icache_req, 1);
    check("rst.addr", icache_addr, RPC);
    check("rst.valid", fetch_valid, 0);
    check("rst.pc", pc, RPC);

    // Randomized run: the bench tracks which instruction decode must see next.
    exp_pc = RPC; busy = 1'b0; lat = 0; consumed = 0; cur_addr = '0;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      rst_n         = 1'b1;
      stall_fetch   = ($urandom_range(0, 2) == 0);
      redirect      = ($urandom_range(0, 15) == 0);
      redirect_addr = {$urandom, $urandom};
      pred_taken_in = btb_hit(pc);
      btb_way_in    = btb_w(pc);
      target_in     = btb_tgt(pc);
      icache_ack    = 1'b0;
      icache_instr  = '0;
      if (icache_req) begin
        if (!busy) begin
          busy     = 1'b1;
          lat      = $urandom_range(0, 3);
          cur_addr = icache_addr;
        end else begin
          check("rnd.addr_stable", icache_addr, cur_addr);
        end
        icache_instr = ihash(cur_addr);
        if (lat == 0) begin
          icache_ack = 1'b1;
          busy       = 1'b0;
        end else begin
          lat--;
        end
      end else if (busy) begin
        check("rnd.req_held", icache_req, 1);
      end
      #1;
      if (redirect) begin
        check("rnd.valid_on_redirect", fetch_valid, 0);
        exp_pc = {redirect_addr[AW-1:2], 2'b00};
      end else if (fetch_valid) begin
        check("rnd.pc", pc, exp_pc);
        check("rnd.pc4", pc_plus4, exp_pc + 64'd4);
        check("rnd.instr", instr, ihash(exp_pc));
        check("rnd.pt", pred_taken_out, btb_hit(exp_pc));
        check("rnd.way", btb_way_out, btb_w(exp_pc));
        check("rnd.tgt", target_out, btb_tgt(exp_pc));
        if (!stall_fetch) begin
          consumed++;
          if (btb_hit(exp_pc)) exp_pc = btb_tgt(exp_pc) & ~64'h3;
          else                 exp_pc = exp_pc + 64'd4;
        end
      end
    end
    check("rnd.progress", (consumed > 300) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
